key_event_scan: RTL and testbench

Parametrised multi-key debouncer and event generator for the clock front panel; successor of the fixed 5-key edge detector. Samples NUM_KEYS raw inputs on a shared divided tick and applies per-key polarity and N-sample stability filtering. Emits single-cycle press, release and long-press events plus a debounced level. Feeds the time-set / mode control logic.

---
 rtl/key_event_scan.sv | 194 +++++++++++++++++++
 tb/tb_key_event_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_event_scan.sv
// Multi-key debouncer for the front panel: synchronises the keys, filters them on a shared sample tick, and emits press/release/long events.
// When KEY_REPEAT_EN is defined, a key in the long-held state also produces auto-repeat pulses.
module key_event_scan #(
    parameter int unsigned         NUM_KEYS     = 5,
    parameter int unsigned         SAMPLE_DIV   = 5000000,
    parameter logic [NUM_KEYS-1:0] ACT_HIGH     = NUM_KEYS'(5'b10000),
    parameter int unsigned         DEB_SAMPLES  = 3,
    parameter int unsigned         LONG_TICKS   = 100,
    parameter int unsigned         REPEAT_TICKS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                tick
);

    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned DEB_W  = $clog2(DEB_SAMPLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("SAMPLE_DIV must be >= 2");
    end
    if (DEB_SAMPLES < 1) begin : g_bad_deb
        $error("DEB_SAMPLES must be >= 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_rep
        $error("REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

    logic [NUM_KEYS-1:0] sync1, sync2, pressed, level_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [DEB_W-1:0]    stab_cnt  [NUM_KEYS];
    state_t              state     [NUM_KEYS];
    state_t              state_nxt [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_cnt  [NUM_KEYS];
    logic [HOLD_W-1:0]   hold_nxt  [NUM_KEYS];
    logic [NUM_KEYS-1:0] long_nxt;
`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0]    rep_cnt   [NUM_KEYS];
    logic [REP_W-1:0]    rep_nxt_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_nxt;
`endif

    assign pressed = ~(sync2 ^ ACT_HIGH);

    // Two-flop synchroniser, reset to the idle pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= ~ACT_HIGH;
            sync2 <= ~ACT_HIGH;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Sample divider; tick is registered so it coincides with div_cnt == SAMPLE_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_W'(SAMPLE_DIV - 2));
            div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_level <= '0;
            for (int i = 0; i < int'(NUM_KEYS); i++) stab_cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (pressed[i] != key_level[i]) begin
                    if (stab_cnt[i] == DEB_W'(DEB_SAMPLES - 1)) begin
                        key_level[i] <= pressed[i];
                        stab_cnt[i]  <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    stab_cnt[i] <= '0;
                end
            end
        end
    end

    // Edge pulses appear the cycle after key_level moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            level_q     <= key_level;
            key_press   <= key_level & ~level_q;
            key_release <= ~key_level & level_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                state[i]    <= S_IDLE;
                hold_cnt[i] <= '0;
`ifdef KEY_REPEAT_EN
                rep_cnt[i]  <= '0;
`endif
            end
            key_long   <= '0;
            key_repeat <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
`ifdef KEY_REPEAT_EN
                rep_cnt[i]  <= rep_nxt_cnt[i];
`endif
            end
            key_long <= long_nxt;
`ifdef KEY_REPEAT_EN
            key_repeat <= rep_nxt;
`else
            key_repeat <= '0;
`endif
        end
    end

    // Per-key hold tracker: a drop of key_level returns to IDLE from any state.
    always_comb begin
        long_nxt = '0;
`ifdef KEY_REPEAT_EN
        rep_nxt  = '0;
`endif
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold_cnt[i];
`ifdef KEY_REPEAT_EN
            rep_nxt_cnt[i] = rep_cnt[i];
`endif
            case (state[i])
                S_IDLE: begin
                    if (key_level[i] && !level_q[i]) begin
                        state_nxt[i] = S_HELD;
                        hold_nxt[i]  = '0;
                    end
                end
                S_HELD: begin
                    if (!key_level[i]) begin
                        state_nxt[i] = S_IDLE;
                    end else if (tick) begin
                        if (hold_cnt[i] == HOLD_W'(LONG_TICKS - 1)) begin
                            state_nxt[i] = S_LONG;
                            hold_nxt[i]  = HOLD_W'(LONG_TICKS);
                            long_nxt[i]  = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_nxt[i]     = 1'b1;
                            rep_nxt_cnt[i] = '0;
`endif
                        end else begin
                            hold_nxt[i] = hold_cnt[i] + HOLD_W'(1);
                        end
                    end
                end
                S_LONG: begin
                    if (!key_level[i]) begin
                        state_nxt[i] = S_IDLE;
`ifdef KEY_REPEAT_EN
                        rep_nxt_cnt[i] = '0;
                    end else if (tick) begin
                        if (rep_cnt[i] == REP_W'(REPEAT_TICKS - 1)) begin
                            rep_nxt[i]     = 1'b1;
                            rep_nxt_cnt[i] = '0;
                        end else begin
                            rep_nxt_cnt[i] = rep_cnt[i] + REP_W'(1);
                        end
`endif
                    end
                end
                default: state_nxt[i] = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_scan.sv
// Randomised scoreboard bench for key_event_scan: a tick-level reference model queues expected pulses, and a monitor pops and compares them.
module tb_key_event_scan;

    localparam int unsigned NK   = 5;
    localparam int unsigned DIV  = 4;
    localparam int unsigned DEB  = 3;
    localparam int unsigned LONG = 8;
    localparam int unsigned REP  = 2;
    localparam logic [NK-1:0] ACT = 5'b10000;
`ifdef KEY_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] rep;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_level, key_press, key_release, key_long, key_repeat;
    logic          tick;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc = 0;
    int  since_rst = 0;
    ev_t q[$];

    logic [NK-1:0] m_lvl, d1, d2;
    int            run  [NK];
    int            held [NK];

    key_event_scan #(
        .NUM_KEYS(NK), .SAMPLE_DIV(DIV), .ACT_HIGH(ACT),
        .DEB_SAMPLES(DEB), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_long(key_long), .key_repeat(key_repeat), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) since_rst = 0;
        else     since_rst++;
    end

    // Reference model: one step per expected sample tick, following the debounce/hold rules directly.
    always @(negedge clk) begin
        logic [NK-1:0] p, pe, re, le, rpe;
        logic          exp_tick;
        if (since_rst == 0) begin
            m_lvl = '0;
            for (int i = 0; i < int'(NK); i++) begin
                run[i]  = 0;
                held[i] = 0;
            end
            while (q.size() > 0 && q[q.size()-1].cyc >= cyc) q.delete(q.size()-1);
        end
        exp_tick = (since_rst % int'(DIV)) == int'(DIV) - 1;
        chk("key_level", 32'(key_level), 32'(m_lvl));
        chk("tick", 32'(tick), 32'(exp_tick));
        if (exp_tick) begin
            p  = ~(d2 ^ ACT);
            pe = '0; re = '0; le = '0; rpe = '0;
            for (int i = 0; i < int'(NK); i++) begin
                if (m_lvl[i]) begin
                    held[i]++;
                    if (held[i] == int'(LONG)) le[i] = 1'b1;
                    if (REP_ON && held[i] >= int'(LONG) && ((held[i] - int'(LONG)) % int'(REP)) == 0)
                        rpe[i] = 1'b1;
                end
                if (p[i] != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] == int'(DEB)) begin
                        m_lvl[i] = p[i];
                        run[i]   = 0;
                        if (p[i]) begin
                            pe[i]   = 1'b1;
                            held[i] = 0;
                        end else begin
                            re[i] = 1'b1;
                        end
                    end
                end else begin
                    run[i] = 0;
                end
            end
            if ((le | rpe) != '0) q.push_back('{cyc + 1, '0, '0, le, rpe});
            if ((pe | re) != '0)  q.push_back('{cyc + 2, pe, re, '0, '0});
        end
        d2 = d1;
        d1 = key_in;
    end

    // Monitor: every cycle the pulse outputs must match the queued event for that cycle, or be zero.
    always @(negedge clk) begin
        logic [NK-1:0] ep, er, el, erp;
        ep = '0; er = '0; el = '0; erp = '0;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_event", 32'(cyc), 32'(q[0].cyc));
            q.delete(0);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ep  = q[0].press;
            er  = q[0].rel;
            el  = q[0].lng;
            erp = q[0].rep;
            q.delete(0);
        end
        chk("key_press", 32'(key_press), 32'(ep));
        chk("key_release", 32'(key_release), 32'(er));
        chk("key_long", 32'(key_long), 32'(el));
        chk("key_repeat", 32'(key_repeat), 32'(erp));
    end

    task automatic drive(input logic [NK-1:0] pr, input int n);
        key_in = ~(pr ^ ACT);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        key_in = ~ACT;
        d1     = ~ACT;
        d2     = ~ACT;
        m_lvl  = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(5'b00000, 10);
        drive(5'b00001, 40);
        drive(5'b00000, 40);
        for (int k = 0; k < 4; k++) begin
            drive(5'b00010, 4);
            drive(5'b00000, 4);
        end
        drive(5'b00010, 24);
        drive(5'b00000, 24);
        drive(5'b10000, 48);
        drive(5'b00000, 24);
        drive(5'b01100, 24);
        rst = 1'b1;
        drive(5'b01100, 2);
        rst = 1'b0;
        drive(5'b01100, 30);
        drive(5'b00000, 24);
        drive(5'b00001, 80);
        drive(5'b00000, 24);
        for (int k = 0; k < 60; k++) begin
            drive(NK'($urandom), int'($urandom_range(1, 40)));
        end
        drive(5'b00000, 60);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
